// File: rtl/mni_wb_mbuf_if.sv
// MNI writeback engine bus bundle.
//  L2C side : o_l2c_wb_space (engine->L2C), i_l2c_wb_valid/i_l2c_wb_adr/i_l2c_data (L2C->engine)
//  Out side : o_out_valid/o_out_data/o_out_eop (engine->consumer), i_out_stall (consumer->engine)
// Signal names keep the engine-centric i_/o_ prefixes so they read the same at both ends.
// slave  = engine view, master = L2C + consumer view.
interface mni_wb_mbuf_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16
);
  logic              o_l2c_wb_space;
  logic              i_l2c_wb_valid;
  logic [31:0]       i_l2c_wb_adr;
  logic [IN_W-1:0]   i_l2c_data;
  logic              o_out_valid;
  logic              i_out_stall;
  logic [OUT_W-1:0]  o_out_data;
  logic              o_out_eop;

  modport slave (
    output o_l2c_wb_space, o_out_valid, o_out_data, o_out_eop,
    input  i_l2c_wb_valid, i_l2c_wb_adr, i_l2c_data, i_out_stall
  );
  modport master (
    input  o_l2c_wb_space, o_out_valid, o_out_data, o_out_eop,
    output i_l2c_wb_valid, i_l2c_wb_adr, i_l2c_data, i_out_stall
  );
endinterface

// File: rtl/mni_wb_mbuf.sv
// MNI writeback engine with an NBUF-slot line buffer.
// L2C writes whole lines (LINE_WORDS beats, address on the first beat); each
// full slot is sent as one packet: HDR_REP copies of the address, then the line,
// all cut into OUT_W flits, MS part first. Packets go back-to-back when the next
// slot is already full.
// Ports: clk_ni (clock), rst_ni (synchronous, active-high reset),
//        wb (mni_wb_mbuf_if.slave: L2C writeback side + out flit side).
module mni_wb_mbuf #(
  parameter int IN_W       = 32,
  parameter int OUT_W      = 16,
  parameter int LINE_WORDS = 16,
  parameter int NBUF       = 2,
  parameter int HDR_REP    = 2
) (
  input  logic           clk_ni,
  input  logic           rst_ni,
  mni_wb_mbuf_if.slave   wb
);
  localparam int R    = IN_W / OUT_W;
  localparam int A    = 32 / OUT_W;
  localparam int HF   = HDR_REP * A;
  localparam int DF   = LINE_WORDS * R;
  localparam int MAXF = (HF > DF) ? HF : DF;
  localparam int FCW  = (MAXF > 1) ? $clog2(MAXF) : 1;
  localparam int WCW  = $clog2(LINE_WORDS);
  localparam int PW   = (NBUF > 1) ? $clog2(NBUF) : 1;
  localparam int UW   = $clog2(NBUF) + 1;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_e;

  logic [NBUF-1:0][LINE_WORDS-1:0][IN_W-1:0] mem_q;
  logic [NBUF-1:0][31:0]                     adr_q;
  logic [NBUF-1:0] full_q, full_d;
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d, rnext;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic [UW-1:0]   used_q, used_d;
  logic [FCW-1:0]  fcnt_q, fcnt_d;
  state_e          state_q, state_d;

  logic space, wr_acc, line_done, out_valid, flit_acc, pkt_end, cur_full, next_full;

  // With a single slot both pointers are pinned at 0.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (NBUF == 1) ? '0 : p + 1'b1;
  endfunction

  assign space     = (wcnt_q == '0) && (used_q < UW'(NBUF));
  // Mid-line beats are always taken; a line start needs space or it is dropped.
  assign wr_acc    = wb.i_l2c_wb_valid && ((wcnt_q != '0) || space);
  assign line_done = wr_acc && (wcnt_q == WCW'(LINE_WORDS-1));
  assign out_valid = (state_q != S_IDLE);
  assign flit_acc  = out_valid && !wb.i_out_stall;
  assign pkt_end   = flit_acc && (state_q == S_DATA) && (fcnt_q == FCW'(DF-1));
  assign rnext     = ptr_inc(rptr_q);
  // A line completing on this edge counts as full so the header starts next cycle.
  assign cur_full  = full_q[rptr_q] || (line_done && (wptr_q == rptr_q));
  assign next_full = (full_q[rnext] && (rnext != rptr_q)) || (line_done && (wptr_q == rnext));

  always_comb begin
    wcnt_d  = wcnt_q;
    wptr_d  = wptr_q;
    full_d  = full_q;
    used_d  = used_q;
    state_d = state_q;
    fcnt_d  = fcnt_q;
    rptr_d  = rptr_q;
    if (wr_acc) wcnt_d = line_done ? '0 : wcnt_q + 1'b1;
    if (line_done) begin
      full_d[wptr_q] = 1'b1;
      wptr_d         = ptr_inc(wptr_q);
    end
    if (pkt_end) full_d[rptr_q] = 1'b0;
    case ({line_done, pkt_end})
      2'b10:   used_d = used_q + 1'b1;
      2'b01:   used_d = used_q - 1'b1;
      default: used_d = used_q;
    endcase
    case (state_q)
      S_IDLE: if (cur_full) begin
        state_d = S_HDR;
        fcnt_d  = '0;
      end
      S_HDR: if (flit_acc) begin
        if (fcnt_q == FCW'(HF-1)) begin
          state_d = S_DATA;
          fcnt_d  = '0;
        end else fcnt_d = fcnt_q + 1'b1;
      end
      S_DATA: if (flit_acc) begin
        if (fcnt_q == FCW'(DF-1)) begin
          rptr_d  = rnext;
          state_d = next_full ? S_HDR : S_IDLE;
          fcnt_d  = '0;
        end else fcnt_d = fcnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_ni) begin
    if (rst_ni) begin
      wcnt_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= '0;
      used_q  <= '0;
      fcnt_q  <= '0;
      state_q <= S_IDLE;
    end else begin
      wcnt_q  <= wcnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= full_d;
      used_q  <= used_d;
      fcnt_q  <= fcnt_d;
      state_q <= state_d;
    end
  end

  // Line storage needs no reset: a slot is only read after it was fully written.
  always_ff @(posedge clk_ni) begin
    if (!rst_ni && wr_acc) begin
      mem_q[wptr_q][wcnt_q] <= wb.i_l2c_data;
      if (wcnt_q == '0) adr_q[wptr_q] <= wb.i_l2c_wb_adr;
    end
  end

  // Combinational read straight out of the slot being sent.
  int              hidx, part;
  logic [WCW-1:0]  widx;
  logic [IN_W-1:0] word;
  logic [OUT_W-1:0] hflit, dflit;

  assign hidx  = int'(fcnt_q) % A;
  assign part  = int'(fcnt_q) % R;
  assign widx  = WCW'(int'(fcnt_q) / R);
  assign word  = mem_q[rptr_q][widx];
  assign hflit = OUT_W'(adr_q[rptr_q] >> (32 - OUT_W*(hidx+1)));
  assign dflit = OUT_W'(word >> (OUT_W*(R-1-part)));

  assign wb.o_l2c_wb_space = space;
  assign wb.o_out_valid    = out_valid;
  assign wb.o_out_data     = (state_q == S_DATA) ? dflit : hflit;
  assign wb.o_out_eop      = (state_q == S_DATA) && (fcnt_q == FCW'(DF-1));
endmodule

// File: tb/tb_mni_wb_mbuf.sv
module tb_mni_wb_mbuf;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mni_wb_mbuf_if #(.IN_W(32), .OUT_W(16)) b1();
  mni_wb_mbuf_if #(.IN_W(64), .OUT_W(8))  b2();

  mni_wb_mbuf #(.IN_W(32), .OUT_W(16), .LINE_WORDS(16), .NBUF(2), .HDR_REP(2))
    dut (.clk_ni(clk), .rst_ni(rst), .wb(b1.slave));
  mni_wb_mbuf #(.IN_W(64), .OUT_W(8), .LINE_WORDS(4), .NBUF(2), .HDR_REP(1))
    dut2 (.clk_ni(clk), .rst_ni(rst), .wb(b2.slave));

  int vec = 0, miss = 0;
  int nflit1 = 0, nflit2 = 0;
  int smode = 0;               // 0: no stall, 1: random 50%, 2: held
  bit mon_en = 1'b0;
  logic [16:0] q1[$], q2[$];   // {eop, flit} expected, flit zero-extended

  // stall driver for dut
  initial forever begin
    @(posedge clk); #1;
    case (smode)
      0:       b1.i_out_stall = 1'b0;
      1:       b1.i_out_stall = 1'($urandom_range(0, 1));
      default: b1.i_out_stall = 1'b1;
    endcase
  end

  // scoreboard monitor, dut
  bit hold1; logic [15:0] pd1; logic pe1;
  always @(negedge clk) begin
    if (mon_en) begin
      if (hold1) begin
        vec++;
        if (b1.o_out_valid !== 1'b1 || b1.o_out_data !== pd1 || b1.o_out_eop !== pe1) begin
          miss++;
          $display("FAIL hold1: got v=%b d=%h e=%b want v=1 d=%h e=%b",
                   b1.o_out_valid, b1.o_out_data, b1.o_out_eop, pd1, pe1);
        end
      end
      if (b1.o_out_valid === 1'b1 && b1.i_out_stall === 1'b0) begin
        logic [16:0] e;
        vec++;
        nflit1++;
        if (q1.size() == 0) begin
          miss++;
          $display("FAIL flit1_extra: got %h want none", {b1.o_out_eop, b1.o_out_data});
        end else begin
          e = q1.pop_front();
          if ({b1.o_out_eop, b1.o_out_data} !== e) begin
            miss++;
            $display("FAIL flit1: got %h want %h", {b1.o_out_eop, b1.o_out_data}, e);
          end
        end
      end
      hold1 = (b1.o_out_valid === 1'b1) && (b1.i_out_stall === 1'b1);
      pd1 = b1.o_out_data;
      pe1 = b1.o_out_eop;
    end else hold1 = 1'b0;
  end

  // scoreboard monitor, dut2 (never stalled)
  always @(negedge clk) begin
    if (mon_en && b2.o_out_valid === 1'b1 && b2.i_out_stall === 1'b0) begin
      logic [16:0] e;
      vec++;
      nflit2++;
      if (q2.size() == 0) begin
        miss++;
        $display("FAIL flit2_extra: got %h want none", {b2.o_out_eop, 8'h00, b2.o_out_data});
      end else begin
        e = q2.pop_front();
        if ({b2.o_out_eop, 8'h00, b2.o_out_data} !== e) begin
          miss++;
          $display("FAIL flit2: got %h want %h", {b2.o_out_eop, 8'h00, b2.o_out_data}, e);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // reference packet: address copies (high part first) then data words, MS part first
  function automatic void push_pkt(input int which, input logic [31:0] adr, input logic [63:0] w[16],
                                   input int in_w, input int out_w, input int lw, input int hrep);
    logic [63:0] mask, f;
    logic [16:0] e;
    int a, r;
    mask = (64'd1 << out_w) - 64'd1;
    a = 32 / out_w;
    r = in_w / out_w;
    for (int h = 0; h < hrep; h++)
      for (int i = 0; i < a; i++) begin
        f = ({32'd0, adr} >> (32 - out_w*(i+1))) & mask;
        e = {1'b0, f[15:0]};
        if (which == 1) q1.push_back(e); else q2.push_back(e);
      end
    for (int k = 0; k < lw; k++)
      for (int p = 0; p < r; p++) begin
        f = (w[k] >> (in_w - out_w*(p+1))) & mask;
        e = {(k == lw-1) && (p == r-1), f[15:0]};
        if (which == 1) q1.push_back(e); else q2.push_back(e);
      end
  endfunction

  function automatic logic sp(input int which);
    return (which == 1) ? b1.o_l2c_wb_space : b2.o_l2c_wb_space;
  endfunction

  task automatic drive_beat(input int which, input logic v, input logic [31:0] adr, input logic [63:0] d);
    if (which == 1) begin
      b1.i_l2c_wb_valid = v; b1.i_l2c_wb_adr = adr; b1.i_l2c_data = d[31:0];
    end else begin
      b2.i_l2c_wb_valid = v; b2.i_l2c_wb_adr = adr; b2.i_l2c_data = d;
    end
  endtask

  task automatic write_line(input int which, input logic [31:0] adr, input logic [63:0] w[16],
                            input int nb, input bit wait_sp, input bit gaps, input bit chk_lat);
    int t = 0;
    if (wait_sp) begin
      do begin @(posedge clk); #1; t++; end while (sp(which) !== 1'b1 && t < 3000);
      if (t >= 3000) begin
        vec++; miss++;
        $display("FAIL space_wait: got %b want 1", sp(which));
      end
    end else begin
      @(posedge clk); #1;
    end
    for (int k = 0; k < nb; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        if (gaps)
          while ($urandom_range(0, 3) == 0) begin
            drive_beat(which, 1'b0, adr, 64'd0);
            @(posedge clk); #1;
          end
      end
      drive_beat(which, 1'b1, adr, w[k]);
      if (chk_lat && k == nb-1) begin
        @(negedge clk);
        vec++;
        if (b1.o_out_valid !== 1'b0) begin
          miss++; $display("FAIL early_valid: got %b want 0", b1.o_out_valid);
        end
      end
    end
    @(posedge clk); #1;
    drive_beat(which, 1'b0, adr, 64'd0);
    if (chk_lat) begin
      @(negedge clk);
      vec++;
      if (b1.o_out_valid !== 1'b1) begin
        miss++; $display("FAIL first_valid: got %b want 1", b1.o_out_valid);
      end
    end
  endtask

  task automatic drain(input int which);
    int t = 0;
    while (((which == 1) ? q1.size() : q2.size()) != 0 && t < 6000) begin
      @(negedge clk); t++;
    end
    if (t >= 6000) begin
      vec++; miss++;
      $display("FAIL drain: got %0d left want 0", (which == 1) ? q1.size() : q2.size());
    end
    repeat (4) @(negedge clk);
    vec++;
    if (((which == 1) ? b1.o_out_valid : b2.o_out_valid) !== 1'b0) begin
      miss++; $display("FAIL idle_after_drain: got 1 want 0");
    end
  endtask

  // wait until the monitor sees an eop flit that is being accepted, then step past that edge
  task automatic wait_eop_acc(input string name);
    int t = 0;
    do begin @(negedge clk); t++; end
    while (!(b1.o_out_valid === 1'b1 && b1.o_out_eop === 1'b1 && b1.i_out_stall === 1'b0) && t < 3000);
    if (t >= 3000) begin
      vec++; miss++; $display("FAIL %s: got no eop want eop", name);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    smode = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    drive_beat(1, 1'b0, 32'd0, 64'd0);
    drive_beat(2, 1'b0, 32'd0, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    q1.delete(); q2.delete();
    @(negedge clk);
    vec++;
    if (b1.o_out_valid !== 1'b0 || b1.o_out_eop !== 1'b0 || b1.o_l2c_wb_space !== 1'b1) begin
      miss++;
      $display("FAIL reset1: got v=%b e=%b s=%b want v=0 e=0 s=1",
               b1.o_out_valid, b1.o_out_eop, b1.o_l2c_wb_space);
    end
    vec++;
    if (b2.o_out_valid !== 1'b0 || b2.o_out_eop !== 1'b0 || b2.o_l2c_wb_space !== 1'b1) begin
      miss++;
      $display("FAIL reset2: got v=%b e=%b s=%b want v=0 e=0 s=1",
               b2.o_out_valid, b2.o_out_eop, b2.o_l2c_wb_space);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_single();
    logic [63:0] w[16];
    int n0;
    for (int k = 0; k < 16; k++) w[k] = {32'd0, 32'h0001_0002 * k};
    push_pkt(1, 32'h8000_0040, w, 32, 16, 16, 2);
    n0 = nflit1;
    write_line(1, 32'h8000_0040, w, 16, 1'b1, 1'b0, 1'b1);
    drain(1);
    vec++;
    if (nflit1 - n0 !== 36) begin
      miss++; $display("FAIL single_count: got %0d want 36", nflit1 - n0);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] w1[16], w2[16];
    for (int k = 0; k < 16; k++) begin
      w1[k] = {32'd0, $urandom}; w2[k] = {32'd0, $urandom};
    end
    push_pkt(1, 32'h1234_5600, w1, 32, 16, 16, 2);
    push_pkt(1, 32'hCAFE_0080, w2, 32, 16, 16, 2);
    write_line(1, 32'h1234_5600, w1, 16, 1'b1, 1'b0, 1'b0);
    vec++;
    if (b1.o_l2c_wb_space !== 1'b1) begin
      miss++; $display("FAIL b2b_space: got %b want 1", b1.o_l2c_wb_space);
    end
    write_line(1, 32'hCAFE_0080, w2, 16, 1'b1, 1'b0, 1'b0);
    wait_eop_acc("b2b_eop");
    vec++;
    if (b1.o_out_valid !== 1'b1 || b1.o_out_data !== 16'hCAFE) begin
      miss++;
      $display("FAIL b2b_gap: got v=%b d=%h want v=1 d=cafe", b1.o_out_valid, b1.o_out_data);
    end
    drain(1);
  endtask

  task automatic test_backpressure();
    logic [63:0] wa[16], wb_[16], wc[16];
    smode = 2;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      wa[k] = {32'd0, $urandom}; wb_[k] = {32'd0, $urandom}; wc[k] = {32'd0, $urandom};
    end
    push_pkt(1, 32'hA000_0000, wa, 32, 16, 16, 2);
    push_pkt(1, 32'hB000_0040, wb_, 32, 16, 16, 2);
    write_line(1, 32'hA000_0000, wa, 16, 1'b1, 1'b0, 1'b0);
    write_line(1, 32'hB000_0040, wb_, 16, 1'b1, 1'b0, 1'b0);
    vec++;
    if (b1.o_l2c_wb_space !== 1'b0) begin
      miss++; $display("FAIL bp_space_full: got %b want 0", b1.o_l2c_wb_space);
    end
    // third line is offered anyway and must vanish
    write_line(1, 32'hC000_0080, wc, 16, 1'b0, 1'b0, 1'b0);
    vec++;
    if (b1.o_l2c_wb_space !== 1'b0 || dut.used_q !== 2'd2) begin
      miss++;
      $display("FAIL bp_drop: got s=%b used=%0d want s=0 used=2", b1.o_l2c_wb_space, dut.used_q);
    end
    smode = 0;
    wait_eop_acc("bp_eop");
    vec++;
    if (b1.o_l2c_wb_space !== 1'b1) begin
      miss++; $display("FAIL bp_space_ret: got %b want 1", b1.o_l2c_wb_space);
    end
    drain(1);
  endtask

  task automatic test_random();
    logic [63:0] w[16];
    logic [31:0] adr;
    smode = 1;
    for (int l = 0; l < 100; l++) begin
      adr = $urandom;
      for (int k = 0; k < 16; k++) w[k] = {32'd0, $urandom};
      push_pkt(1, adr, w, 32, 16, 16, 2);
      write_line(1, adr, w, 16, 1'b1, 1'b1, 1'b0);
    end
    drain(1);
    smode = 0;
  endtask

  task automatic test_reset_mid();
    logic [63:0] wa[16], wh[16], wc[16];
    int t = 0;
    for (int k = 0; k < 16; k++) begin
      wa[k] = {32'd0, $urandom}; wh[k] = {32'd0, $urandom}; wc[k] = {32'd0, $urandom};
    end
    smode = 2;
    push_pkt(1, 32'hD000_0000, wa, 32, 16, 16, 2);
    write_line(1, 32'hD000_0000, wa, 16, 1'b1, 1'b0, 1'b0);
    write_line(1, 32'hE000_0040, wh, 8, 1'b1, 1'b0, 1'b0);
    smode = 0;
    while (q1.size() > 28 && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) begin
      vec++; miss++; $display("FAIL mid_wait: got %0d left want <=28", q1.size());
    end
    do_reset();
    push_pkt(1, 32'hF000_00C0, wc, 32, 16, 16, 2);
    write_line(1, 32'hF000_00C0, wc, 16, 1'b1, 1'b0, 1'b0);
    drain(1);
  endtask

  task automatic test_narrow();
    logic [63:0] w[16];
    int n0;
    for (int k = 0; k < 16; k++) w[k] = (k < 4) ? {$urandom, $urandom} : 64'd0;
    push_pkt(2, 32'h1357_9BDF, w, 64, 8, 4, 1);
    n0 = nflit2;
    write_line(2, 32'h1357_9BDF, w, 4, 1'b1, 1'b0, 1'b0);
    drain(2);
    vec++;
    if (nflit2 - n0 !== 36) begin
      miss++; $display("FAIL narrow_count: got %0d want 36", nflit2 - n0);
    end
  endtask

  initial begin
    rst = 1'b1;
    b1.i_out_stall = 1'b0;
    b2.i_out_stall = 1'b0;
    drive_beat(1, 1'b0, 32'd0, 64'd0);
    drive_beat(2, 1'b0, 32'd0, 64'd0);
    repeat (3) @(posedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_narrow();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
